// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for the immediate-extension pipe: an input beat channel
// (immediate, mode, tag) and an output beat channel (operand, tag).
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    // Producer of input beats and consumer of output beats (decode side).
    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // The extension unit itself.
    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate-extension unit. The extended operand is computed on the
// input side and registered into an output stage backed by a one-entry skid
// buffer, so in_ready comes straight from a flop and never from out_ready.
module imm_extend_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    imm_extend_pipe_if.slave  bus
);
    localparam int EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // Extension of one immediate according to its mode.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                    input logic [1:0]      mode);
        logic [OUT_W-1:0] sext_v;
        sext_v = {{EXT_W{imm[IN_W-1]}}, imm};
        case (mode)
            MODE_SEXT:   extend_imm = sext_v;
            MODE_ZEXT:   extend_imm = {{EXT_W{1'b0}}, imm};
            MODE_UPPER:  extend_imm = {imm, {EXT_W{1'b0}}};
            MODE_BRANCH: extend_imm = sext_v << BR_SHIFT;
            default:     extend_imm = sext_v;
        endcase
    endfunction

    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             skid_valid_r;
    logic [OUT_W-1:0] skid_data_r;
    logic [TAG_W-1:0] skid_tag_r;

    logic             out_valid_s;
    logic [OUT_W-1:0] out_data_s;
    logic [TAG_W-1:0] out_tag_s;
    logic             skid_valid_s;
    logic [OUT_W-1:0] skid_data_s;
    logic [TAG_W-1:0] skid_tag_s;

    logic             in_fire_s;
    logic             out_load_s;
    logic [OUT_W-1:0] ext_data_s;

    assign bus.in_ready  = ~skid_valid_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_tag   = out_tag_r;

    assign in_fire_s  = bus.in_valid & ~skid_valid_r;
    // The output register may take a new beat when it is empty or draining.
    assign out_load_s = ~out_valid_r | bus.out_ready;
    assign ext_data_s = extend_imm(bus.in_data, bus.in_mode);

    // Next-state steering between input, skid buffer and output register.
    always_comb begin
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        out_tag_s    = out_tag_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        skid_tag_s   = skid_tag_r;
        if (flush) begin
            // Flush wins over any beat offered in the same cycle.
            out_valid_s  = 1'b0;
            skid_valid_s = 1'b0;
        end else if (out_load_s) begin
            if (skid_valid_r) begin
                // Oldest beat lives in the skid buffer; input is blocked here.
                out_valid_s  = 1'b1;
                out_data_s   = skid_data_r;
                out_tag_s    = skid_tag_r;
                skid_valid_s = 1'b0;
            end else if (in_fire_s) begin
                out_valid_s = 1'b1;
                out_data_s  = ext_data_s;
                out_tag_s   = bus.in_tag;
            end else begin
                out_valid_s = 1'b0;
            end
        end else begin
            // Output stalled: park an accepted beat in the skid buffer.
            if (in_fire_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = ext_data_s;
                skid_tag_s   = bus.in_tag;
            end else begin
                skid_valid_s = skid_valid_r;
            end
        end
    end

    // Pipeline state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {OUT_W{1'b0}};
            out_tag_r    <= {TAG_W{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {OUT_W{1'b0}};
            skid_tag_r   <= {TAG_W{1'b0}};
        end else begin
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            out_tag_r    <= out_tag_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            skid_tag_r   <= skid_tag_s;
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: default instance plus a
// 12->20 bit instance with BR_SHIFT = 1, both scoreboarded.
module tb_imm_extend_pipe;
    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
    } exp_a_t;
    typedef struct {
        logic [19:0] d;
        logic [4:0]  t;
    } exp_b_t;

    logic clk;
    logic rst_n;
    logic flush;

    int n_checks;
    int n_pass;

    exp_a_t     q_a[$];
    exp_b_t     q_b[$];
    logic [4:0] got_tags[$];

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus_a ();
    imm_extend_pipe_if #(.IN_W(12), .OUT_W(20), .TAG_W(5)) bus_b ();

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2), .TAG_W(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_a)
    );
    imm_extend_pipe #(.IN_W(12), .OUT_W(20), .BR_SHIFT(1), .TAG_W(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model, default geometry: signed arithmetic rather than bit splicing.
    function automatic logic [31:0] ref_a(input logic [15:0] d, input logic [1:0] m);
        logic signed [31:0] s;
        s = $signed(d);
        case (m)
            2'd0:    ref_a = s;
            2'd1:    ref_a = {16'h0000, d};
            2'd2:    ref_a = {d, 16'h0000};
            default: ref_a = s * 32'sd4;
        endcase
    endfunction

    // Reference model, 12->20 geometry with a branch shift of one.
    function automatic logic [19:0] ref_b(input logic [11:0] d, input logic [1:0] m);
        logic signed [19:0] s;
        s = $signed(d);
        case (m)
            2'd0:    ref_b = s;
            2'd1:    ref_b = {8'h00, d};
            2'd2:    ref_b = {d, 8'h00};
            default: ref_b = s * 20'sd2;
        endcase
    endfunction

    // Advance one clock: at the falling edge score output transfers and log input transfers.
    task automatic tick();
        @(negedge clk);
        if (bus_a.out_valid && bus_a.out_ready) begin
            n_checks++;
            if (q_a.size() == 0) begin
                $display("FAIL sb_a_unexpected: got tag %0d data %h, required no beat", bus_a.out_tag, bus_a.out_data);
            end else begin
                exp_a_t e;
                e = q_a.pop_front();
                if (bus_a.out_data !== e.d || bus_a.out_tag !== e.t)
                    $display("FAIL sb_a: got %h/%0d, required %h/%0d", bus_a.out_data, bus_a.out_tag, e.d, e.t);
                else
                    n_pass++;
            end
            got_tags.push_back(bus_a.out_tag);
        end
        if (bus_b.out_valid && bus_b.out_ready) begin
            n_checks++;
            if (q_b.size() == 0) begin
                $display("FAIL sb_b_unexpected: got tag %0d data %h, required no beat", bus_b.out_tag, bus_b.out_data);
            end else begin
                exp_b_t e;
                e = q_b.pop_front();
                if (bus_b.out_data !== e.d || bus_b.out_tag !== e.t)
                    $display("FAIL sb_b: got %h/%0d, required %h/%0d", bus_b.out_data, bus_b.out_tag, e.d, e.t);
                else
                    n_pass++;
            end
        end
        if (flush) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (bus_a.in_valid && bus_a.in_ready)
                q_a.push_back('{d: ref_a(bus_a.in_data, bus_a.in_mode), t: bus_a.in_tag});
            if (bus_b.in_valid && bus_b.in_ready)
                q_b.push_back('{d: ref_b(bus_b.in_data, bus_b.in_mode), t: bus_b.in_tag});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [15:0] d, input logic [1:0] m, input logic [4:0] t);
        bus_a.in_valid = v;
        bus_a.in_data  = d;
        bus_a.in_mode  = m;
        bus_a.in_tag   = t;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 32'h0 || bus_a.out_tag !== 5'h0)
            $display("FAIL reset_state: got v=%b d=%h t=%0d, required 0/0/0", bus_a.out_valid, bus_a.out_data, bus_a.out_tag);
        else
            n_pass++;
        #5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_a.in_ready !== 1'b1 || bus_b.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b/%b, required 1/1", bus_a.in_ready, bus_b.in_ready);
        else
            n_pass++;
    endtask

    task automatic test_modes();
        logic [15:0] vd[5];
        logic [1:0]  vm[5];
        logic [31:0] ve[5];
        vd = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFE, 16'h7FFF};
        vm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        ve = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFF8, 32'h0001FFFC};
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b1, vd[i], vm[i], 5'(i + 20));
            tick();
            drive_a(1'b0, 16'h0, 2'd0, 5'd0);
            n_checks++;
            if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== ve[i] || bus_a.out_tag !== 5'(i + 20))
                $display("FAIL mode_%0d: got v=%b d=%h t=%0d, required 1/%h/%0d", i, bus_a.out_valid, bus_a.out_data, bus_a.out_tag, ve[i], i + 20);
            else
                n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        got_tags.delete();
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus_a.in_ready !== 1'b1) bad++;
            drive_a(1'b1, 16'(i * 4099), 2'(i), 5'(i));
            tick();
        end
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        tick();
        tick();
        n_checks++;
        if (bad != 0 || got_tags.size() != 8)
            $display("FAIL back_to_back: got %0d stalls and %0d beats, required 0 and 8", bad, got_tags.size());
        else
            n_pass++;
    endtask

    task automatic test_backpressure();
        logic done;
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, 16'h0011, 2'd1, 5'd1);
        tick();
        drive_a(1'b1, 16'h0022, 2'd0, 5'd2);
        tick();
        drive_a(1'b1, 16'h0033, 2'd2, 5'd3);
        n_checks++;
        if (bus_a.in_ready !== 1'b0 || bus_a.out_valid !== 1'b1 || bus_a.out_tag !== 5'd1)
            $display("FAIL skid_full: got rdy=%b v=%b tag=%0d, required 0/1/1", bus_a.in_ready, bus_a.out_valid, bus_a.out_tag);
        else
            n_pass++;
        tick();
        n_checks++;
        if (bus_a.in_ready !== 1'b0 || bus_a.out_tag !== 5'd1 || bus_a.out_data !== 32'h00000011)
            $display("FAIL stall_hold: got rdy=%b tag=%0d d=%h, required 0/1/00000011", bus_a.in_ready, bus_a.out_tag, bus_a.out_data);
        else
            n_pass++;
        got_tags.delete();
        bus_a.out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (bus_a.in_ready === 1'b1) done = 1'b1;
            tick();
        end
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (!done || got_tags.size() != 3 || got_tags[0] !== 5'd1 || got_tags[1] !== 5'd2 || got_tags[2] !== 5'd3)
            $display("FAIL drain_order: got accepted=%b count=%0d, required 1 and tags 1,2,3", done, got_tags.size());
        else
            n_pass++;
    endtask

    task automatic test_flush();
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, 16'h0007, 2'd0, 5'd7);
        tick();
        drive_a(1'b1, 16'h0008, 2'd0, 5'd8);
        tick();
        flush = 1'b1;
        drive_a(1'b1, 16'h0009, 2'd0, 5'd9);
        tick();
        flush = 1'b0;
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1)
            $display("FAIL flush_full: got v=%b rdy=%b, required 0/1", bus_a.out_valid, bus_a.in_ready);
        else
            n_pass++;
        drive_a(1'b1, 16'h000A, 2'd1, 5'd10);
        tick();
        flush = 1'b1;
        drive_a(1'b1, 16'h000B, 2'd1, 5'd11);
        tick();
        flush = 1'b0;
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.in_ready !== 1'b1)
            $display("FAIL flush_priority: got v=%b rdy=%b, required 0/1", bus_a.out_valid, bus_a.in_ready);
        else
            n_pass++;
        got_tags.delete();
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (got_tags.size() != 0)
            $display("FAIL flush_leak: got %0d beats after flush, required 0", got_tags.size());
        else
            n_pass++;
    endtask

    task automatic test_async_reset();
        bus_a.out_ready = 1'b0;
        drive_a(1'b1, 16'h0005, 2'd1, 5'd12);
        tick();
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        n_checks++;
        if (bus_a.out_valid !== 1'b1)
            $display("FAIL pre_reset_valid: got %b, required 1", bus_a.out_valid);
        else
            n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 32'h0 || bus_a.in_ready !== 1'b1)
            $display("FAIL async_reset: got v=%b d=%h rdy=%b, required 0/00000000/1", bus_a.out_valid, bus_a.out_data, bus_a.in_ready);
        else
            n_pass++;
        q_a.delete();
        q_b.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b1;
        drive_a(1'b1, 16'h00FF, 2'd0, 5'd13);
        tick();
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        n_checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 32'h000000FF || bus_a.out_tag !== 5'd13)
            $display("FAIL post_reset_latency: got v=%b d=%h t=%0d, required 1/000000FF/13", bus_a.out_valid, bus_a.out_data, bus_a.out_tag);
        else
            n_pass++;
        tick();
    endtask

    task automatic test_sweep();
        bus_b.out_ready = 1'b1;
        bus_b.in_valid  = 1'b1;
        bus_b.in_data   = 12'h800;
        bus_b.in_mode   = 2'd3;
        bus_b.in_tag    = 5'd30;
        tick();
        bus_b.in_valid = 1'b0;
        n_checks++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out_data !== 20'hFF000)
            $display("FAIL sweep_branch: got v=%b d=%h, required 1/FF000", bus_b.out_valid, bus_b.out_data);
        else
            n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flush           = ($urandom_range(0, 31) == 0);
            bus_a.in_valid  = 1'($urandom_range(0, 1));
            bus_a.in_data   = 16'($urandom);
            bus_a.in_mode   = 2'($urandom_range(0, 3));
            bus_a.in_tag    = 5'($urandom);
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            bus_b.in_valid  = 1'($urandom_range(0, 1));
            bus_b.in_data   = 12'($urandom);
            bus_b.in_mode   = 2'($urandom_range(0, 3));
            bus_b.in_tag    = 5'($urandom);
            bus_b.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        flush = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0)
            $display("FAIL random_drain: got %0d/%0d beats outstanding, required 0/0", q_a.size(), q_b.size());
        else
            n_pass++;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    // Test sequence.
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        drive_a(1'b0, 16'h0, 2'd0, 5'd0);
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = 12'h0;
        bus_b.in_mode   = 2'd0;
        bus_b.in_tag    = 5'd0;
        bus_b.out_ready = 1'b0;
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate-extension unit for the decode stage.
- Takes an IN_W-bit immediate plus a mode select and produces an OUT_W-bit operand.
- Modes are sign-extend, zero-extend, upper-load, and branch-offset (sign-extend then shift).
- Results pass through a registered output stage with a one-entry skid buffer and valid/ready handshakes, so decode stalls and flushes are absorbed without combinational ready paths.

Parameters:
- IN_W, 16: immediate input width. Legal range is 1 ≤ IN_W < OUT_W.
- OUT_W, 32: extended output width.
- BR_SHIFT, 2: left shift applied in branch mode. Legal range is 0 ≤ BR_SHIFT < OUT_W.
- TAG_W, 5: width of the sideband tag carried alongside the data (e.g. destination register).

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous pipeline flush.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: unit can accept an input beat.
- in_data, input, IN_W: immediate value.
- in_mode, input, 2: extension mode. 00 = SEXT, 01 = ZEXT, 10 = UPPER, 11 = BRANCH.
- in_tag, input, TAG_W: sideband tag, passed through unchanged.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: downstream accepts the output beat.
- out_data, output, OUT_W: extended result.
- out_tag, output, TAG_W: tag associated with out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 0, out_data = 0, out_tag = 0.
  - Skid buffer cleared (skid_valid = 0).
  - in_ready = 1 once rst_n is high.
- Arithmetic, computed combinationally on the input side before registering (E = OUT_W − IN_W):
  - SEXT: {E copies of in_data[IN_W−1], in_data}.
  - ZEXT: {E zeros, in_data}.
  - UPPER: {in_data, E zeros}. If IN_W > E, the low E bits are zero and in_data occupies the top IN_W bits.
  - BRANCH: (SEXT result) << BR_SHIFT. Bits shifted past bit OUT_W−1 are discarded; vacated low bits are zero.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready is driven directly from a register: in_ready = ~skid_valid. It has no combinational dependence on out_ready.
- Data movement, per cycle, when flush = 0:
  - Output stage empty, or output transferring this cycle: the result comes from the skid buffer if it is occupied, otherwise from the accepted input.
  - Skid buffer occupied and output transferring: if an input is accepted that cycle, it refills the skid buffer. That input cannot be accepted anyway, because in_ready = 0 while the skid buffer is full.
  - Output stage full, not transferring, and an input accepted: the input goes to the skid buffer, so in_ready = 0 from the next cycle.
  - Output stage not transferring: out_data and out_tag hold stable.
- Latency: 1 cycle from input acceptance to out_valid when the pipe is empty.
- Throughput: 1 beat per cycle while out_ready = 1.
- Ordering: strictly FIFO, and no beat is lost or duplicated.
- flush:
  - On the next edge, clears out_valid and skid_valid.
  - Flush has priority over an input transfer in the same cycle; that beat is dropped.
  - out_data and out_tag are not required to clear.
- Reset asserted mid-transfer: all state is cleared immediately and pending beats are discarded.
- in_mode and in_tag are sampled only at input acceptance.

Test Plan:
- SEXT/ZEXT, default parameters: in_data = 16'h8001, mode 00 → out_data = 32'hFFFF8001 one cycle later. Same input with mode 01 → 32'h00008001.
- UPPER and BRANCH: in_data = 16'h1234, mode 10 → 32'h12340000. in_data = 16'hFFFE, mode 11 → 32'hFFFFFFF8. in_data = 16'h7FFF, mode 11 → 32'h0001FFFC.
- Backpressure and skid: stream tags 1, 2, 3 with in_valid = 1 and hold out_ready = 0 from cycle 1.
  - Required: out_tag = 1 held stable, tag 2 captured in the skid buffer, in_ready = 0, tag 3 not accepted.
  - Then raise out_ready: tags emerge in the order 1, 2, 3 with none lost.
- Flush priority: output and skid both full, assert flush together with in_valid → next cycle out_valid = 0, in_ready = 1, and the flushed-cycle beat never appears.
- Async reset: drop rst_n between clock edges while out_valid = 1 → out_valid = 0 immediately, without waiting for a clock edge. After release, first accepted beat appears after 1 cycle.
- Parameter sweep: IN_W = 12, OUT_W = 20, BR_SHIFT = 1, input 12'h800, mode 11 → 20'hFF000. Random streams checked against a reference model with random out_ready.
